// File: rtl/controlador_memoria_principal_if.sv
// Cache <-> main-memory request/completion bus.
// The cache drives the master side and the memory controller drives the slave side.
interface controlador_memoria_principal_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wren;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              ack;
    logic              ack_wr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output req_valid, req_wren, req_addr, req_data,
        input  req_ready, ack, ack_wr, rd_data
    );

    modport slave (
        input  req_valid, req_wren, req_addr, req_data,
        output req_ready, ack, ack_wr, rd_data
    );
endinterface

// File: rtl/controlador_memoria_principal.sv
// Main-memory responder: queues cache write-back/refill requests in a 2-entry FIFO,
// serves them in order after a fixed latency, and acks each completion for one cycle.
module controlador_memoria_principal #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 3,
    parameter int LATENCY = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    controlador_memoria_principal_if.slave  bus,
    output logic [7:0]                      rd_count,
    output logic [7:0]                      wr_count
);
    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    typedef struct packed {
        logic              wren;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;
    logic              push, pop, commit;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    req_t              cur_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    assign bus.req_ready = (count != 2'd2);
    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = (state_q == IDLE) && (count != 2'd0);
    assign commit        = (state_q == WAIT) && (cnt_q == 4'd0);

    // FIFO storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{wren: bus.req_wren, addr: bus.req_addr, data: bus.req_data};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of the order the always_ff blocks are evaluated in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: next-state is assigned a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count != 2'd0) state_d = WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                cur_q <= fifo_mem[rd_ptr];
                cnt_q <= WAIT_INIT;
            end else if (state_q == WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // NOTE: the backing store is built from resettable flops because reset must
    // restore the mem[i] = i pattern; a RAM macro could not be used here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
            rd_data_q <= '0;
            rd_count  <= 8'd0;
            wr_count  <= 8'd0;
        end else if (commit) begin
            if (cur_q.wren) begin
                mem[cur_q.addr] <= cur_q.data;
                if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
            end else begin
                rd_data_q <= mem[cur_q.addr];
                if (rd_count != 8'hFF) rd_count <= rd_count + 8'd1;
            end
        end
    end

    assign bus.ack     = (state_q == DONE);
    assign bus.ack_wr  = (state_q == DONE) && cur_q.wren;
    assign bus.rd_data = rd_data_q;
endmodule

// File: tb/tb_controlador_memoria_principal.sv
// Directed bench for controlador_memoria_principal: latency, ordering, back-pressure,
// reset while busy and counter saturation, with hand-computed expectations.
module tb_controlador_memoria_principal;
    logic       clock;
    logic       reset;
    logic [7:0] rd_count;
    logic [7:0] wr_count;
    int         cyc;
    int         tests;
    int         fails;

    int         ack_cyc [$];
    logic       ack_wrq [$];
    logic [2:0] ack_rdq [$];
    logic [7:0] ack_rcq [$];

    controlador_memoria_principal_if #(.ADDR_W(4), .DATA_W(3)) bus ();

    controlador_memoria_principal #(.ADDR_W(4), .DATA_W(3), .LATENCY(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Completion log, sampled on the falling edge.
    always @(negedge clock) begin
        if (bus.ack === 1'b1) begin
            ack_cyc.push_back(cyc);
            ack_wrq.push_back(bus.ack_wr);
            ack_rdq.push_back(bus.rd_data);
            ack_rcq.push_back(rd_count);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        ack_cyc.delete();
        ack_wrq.delete();
        ack_rdq.delete();
        ack_rcq.delete();
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Entered at a falling edge; leaves req_valid high and returns the accept cycle.
    task automatic send(input logic w, input logic [3:0] a, input logic [2:0] d, output int t);
        bit done;
        done = 1'b0;
        t    = -1;
        bus.req_valid = 1'b1;
        bus.req_wren  = w;
        bus.req_addr  = a;
        bus.req_data  = d;
        for (int k = 0; k < 50 && !done; k++) begin
            done = bus.req_ready;
            @(posedge clock);
            @(negedge clock);
            if (done) t = cyc;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_acks(input int n, input int budget);
        for (int k = 0; k < budget && ack_cyc.size() < n; k++) begin
            @(negedge clock);
            #1;
        end
        check("ack_count", ack_cyc.size(), n);
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int t, t2;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wren  = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        repeat (3) @(negedge clock);
        check("rst_ready",    bus.req_ready, 1);
        check("rst_ack",      bus.ack, 0);
        check("rst_ack_wr",   bus.ack_wr, 0);
        check("rst_rd_data",  bus.rd_data, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_wr_count", wr_count, 0);
        reset = 1'b0;
        idle(2);

        // 1: single read of addr 5, ack three cycles after acceptance
        clear_log();
        send(1'b0, 4'd5, 3'd0, t);
        idle(0);
        wait_acks(1, 20);
        check("t1_ack_cycle", ack_cyc[0], t + 3);
        check("t1_ack_wr",    ack_wrq[0], 0);
        check("t1_rd_data",   ack_rdq[0], 3'b101);
        check("t1_rd_count",  rd_count, 1);
        idle(3);

        // 2: write 9 <- 6 then read 9
        clear_log();
        send(1'b1, 4'd9, 3'b110, t);
        send(1'b0, 4'd9, 3'd0, t2);
        idle(0);
        wait_acks(2, 30);
        check("t2_ack0_wr",   ack_wrq[0], 1);
        check("t2_ack0_rd",   ack_rdq[0], 3'b101);
        check("t2_ack0_cyc",  ack_cyc[0], t + 3);
        check("t2_ack1_wr",   ack_wrq[1], 0);
        check("t2_ack1_rd",   ack_rdq[1], 3'b110);
        check("t2_spacing",   ack_cyc[1] - ack_cyc[0], 4);
        check("t2_wr_count",  wr_count, 1);
        check("t2_rd_count",  rd_count, 2);
        idle(3);

        // 3: four back-to-back requests; FIFO fills on the third push
        clear_log();
        send(1'b1, 4'd10, 3'd1, t);
        send(1'b0, 4'd10, 3'd0, t2);
        send(1'b0, 4'd3,  3'd0, t2);
        check("t3_full_ready", bus.req_ready, 0);
        send(1'b0, 4'd12, 3'd0, t2);
        check("t3_d_accept",  t2, t + 6);
        idle(0);
        wait_acks(4, 40);
        check("t3_ack0_cyc",  ack_cyc[0], t + 3);
        check("t3_ack1_cyc",  ack_cyc[1], t + 7);
        check("t3_ack2_cyc",  ack_cyc[2], t + 11);
        check("t3_ack3_cyc",  ack_cyc[3], t + 15);
        check("t3_ack0_wr",   ack_wrq[0], 1);
        check("t3_ack0_rd",   ack_rdq[0], 3'b110);
        check("t3_ack1_wr",   ack_wrq[1], 0);
        check("t3_ack1_rd",   ack_rdq[1], 3'd1);
        check("t3_ack2_rd",   ack_rdq[2], 3'd3);
        check("t3_ack3_rd",   ack_rdq[3], 3'd4);
        check("t3_wr_count",  wr_count, 2);
        check("t3_rd_count",  rd_count, 5);
        idle(3);

        // 4: write-back then refill back to back, then read back the written word
        clear_log();
        send(1'b1, 4'd2, 3'b111, t);
        send(1'b0, 4'd6, 3'd0, t2);
        send(1'b0, 4'd2, 3'd0, t2);
        idle(0);
        wait_acks(3, 40);
        check("t4_ack0_wr",   ack_wrq[0], 1);
        check("t4_ack1_wr",   ack_wrq[1], 0);
        check("t4_refill",    ack_rdq[1], 3'b110);
        check("t4_mem2",      ack_rdq[2], 3'b111);
        check("t4_wr_count",  wr_count, 3);
        check("t4_rd_count",  rd_count, 7);
        idle(3);

        // 5: reset while a write is in WAIT and another write is queued
        clear_log();
        send(1'b1, 4'd4, 3'd7, t);
        send(1'b1, 4'd5, 3'd0, t2);
        do_reset();
        idle(6);
        check("t5_no_ack",    ack_cyc.size(), 0);
        check("t5_ready",     bus.req_ready, 1);
        check("t5_rd_data",   bus.rd_data, 0);
        check("t5_rd_count",  rd_count, 0);
        check("t5_wr_count",  wr_count, 0);
        send(1'b0, 4'd4, 3'd0, t);
        send(1'b0, 4'd5, 3'd0, t);
        send(1'b0, 4'd9, 3'd0, t);
        idle(0);
        wait_acks(3, 40);
        check("t5_mem4",      ack_rdq[0], 3'd4);
        check("t5_mem5",      ack_rdq[1], 3'd5);
        check("t5_mem9",      ack_rdq[2], 3'd1);
        idle(3);

        // 6: 300 reads from reset; rd_count saturates at 255
        do_reset();
        idle(2);
        clear_log();
        for (int i = 0; i < 300; i++) begin
            send(1'b0, 4'(i), 3'd0, t);
        end
        idle(0);
        wait_acks(300, 2000);
        check("t6_count_254", ack_rcq[253], 254);
        check("t6_count_255", ack_rcq[254], 255);
        check("t6_count_hold", ack_rcq[299], 255);
        check("t6_rd_count",  rd_count, 255);
        check("t6_last_data", ack_rdq[299], 3'd3);
        check("t6_wr_count",  wr_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
